// File: rtl/fft_stream_pkg.sv
// Shared types for the FFT result path: writer, bin streamer and peak detector.
// bin_pair_t packs {real0, imag0, real1, imag1}, matching the RAM word layout.
package fft_stream_pkg;

  localparam int DW     = 16;
  localparam int NPAIRS = 256;
  localparam int IDX_W  = 9;
  localparam logic [IDX_W-1:0] MARK_IDX = 9'd256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    MARK  = 2'd3
  } stream_state_t;

  typedef struct packed {
    logic signed [DW-1:0] real0;
    logic signed [DW-1:0] imag0;
    logic signed [DW-1:0] real1;
    logic signed [DW-1:0] imag1;
  } bin_pair_t;

endpackage

// File: rtl/fft_bin_streamer_bin_pipe.sv
// Delay line that lines up the issued pair index with RAM read data, then
// captures index, data and data gate in one register so they always match.
module bin_pipe
  import fft_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  input  logic [AW-1:0]    in_idx_i,
  input  bin_pair_t        rdata_i,
  input  logic             mark_i,
  output logic [IDX_W-1:0] out_idx_o,
  output bin_pair_t        out_data_o,
  output logic             out_gate_o
);

  // DEPTH-1 shadow stages cover the RAM latency; the last stage is the capture.
  localparam int SH = DEPTH - 1;

  logic [SH-1:0] sh_v_q;
  logic [AW-1:0] sh_idx_q [SH];

  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  bin_pair_t        out_data_q, out_data_d;
  logic             out_gate_q, out_gate_d;

  always_comb begin
    out_idx_d  = '0;
    out_data_d = '0;
    out_gate_d = 1'b1;
    if (sh_v_q[SH-1]) begin
      out_idx_d  = IDX_W'(sh_idx_q[SH-1]);
      out_data_d = rdata_i;
      out_gate_d = 1'b0;
    end else if (mark_i) begin
      out_idx_d  = MARK_IDX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sh_v_q     <= '0;
      for (int i = 0; i < SH; i++) sh_idx_q[i] <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      out_gate_q <= 1'b1;
    end else begin
      sh_v_q[0]   <= in_valid_i;
      sh_idx_q[0] <= in_idx_i;
      for (int i = 1; i < SH; i++) begin
        sh_v_q[i]   <= sh_v_q[i-1];
        sh_idx_q[i] <= sh_idx_q[i-1];
      end
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      out_gate_q <= out_gate_d;
    end
  end

  assign out_idx_o  = out_idx_q;
  assign out_data_o = out_data_q;
  assign out_gate_o = out_gate_q;

endmodule

// File: rtl/fft_bin_streamer.sv
// Sweeps the FFT result RAM two bins per cycle, then holds index 256 as the
// frame-end marker before returning to 0 to clear the downstream peak search.
module fft_bin_streamer
  import fft_stream_pkg::stream_state_t, fft_stream_pkg::bin_pair_t,
         fft_stream_pkg::IDLE, fft_stream_pkg::READ, fft_stream_pkg::DRAIN,
         fft_stream_pkg::MARK, fft_stream_pkg::IDX_W;
#(
  parameter int DW     = 16,
  parameter int NPAIRS = 256,
  parameter int HOLD   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [7:0]           ram_addr,
  output logic                 ram_ren,
  input  logic [4*DW-1:0]      ram_rdata,
  output logic [IDX_W-1:0]     output_index,
  output logic signed [DW-1:0] real0,
  output logic signed [DW-1:0] imag0,
  output logic signed [DW-1:0] real1,
  output logic signed [DW-1:0] imag1,
  output logic                 reset_fft,
  output logic                 busy,
  output logic                 done,
  output stream_state_t        dbg_state
);

  localparam int         DEPTH     = 2;
  localparam logic [7:0] LAST_ADDR = 8'(NPAIRS - 1);
  localparam logic [7:0] DRAIN_END = 8'(DEPTH - 2);
  localparam logic [7:0] MARK_OFF  = 8'(HOLD - 1);
  localparam logic [7:0] MARK_END  = 8'(HOLD);

  stream_state_t state_q;
  logic [7:0]    addr_q;
  logic [7:0]    cnt_q;
  logic          ren_q;
  logic          busy_q;
  logic          done_q;
  logic          mark_q;

  // Start is only looked at in IDLE, so a start during a sweep is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            addr_q  <= '0;
            ren_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          addr_q <= addr_q + 8'd1;
          if (addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
            ren_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == DRAIN_END) begin
            state_q <= MARK;
            mark_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        MARK: begin
          // mark_q leads the visible marker by one cycle; busy drops with it.
          cnt_q  <= cnt_q + 8'd1;
          done_q <= (cnt_q == 8'd0);
          if (cnt_q == MARK_OFF) mark_q <= 1'b0;
          if (cnt_q == MARK_END) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bin_pair_t pair;

  bin_pipe #(
    .DEPTH (DEPTH),
    .AW    (8)
  ) u_pipe (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (ren_q),
    .in_idx_i   (addr_q),
    .rdata_i    (ram_rdata),
    .mark_i     (mark_q),
    .out_idx_o  (output_index),
    .out_data_o (pair),
    .out_gate_o (reset_fft)
  );

  assign ram_addr  = addr_q;
  assign ram_ren   = ren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign real0     = pair.real0;
  assign imag0     = pair.imag0;
  assign real1     = pair.real1;
  assign imag1     = pair.imag1;

endmodule

// File: doc/fft_bin_streamer.md
# fft_bin_streamer

Drives the FFT output-bin stream consumed by the spectral peak detector. On a start pulse, sweeps the FFT result RAM two bins per cycle and presents each pair with its bin-pair index. At the end of the sweep it raises index bit 8 as the frame-end marker, then returns the index to 0, which clears the downstream peak search. It sits between the FFT core's result memory and the peak-detect stage.

## Interface

Parameters:
- `DW`, 16: signed width of each real/imag component.
- `NPAIRS`, 256: bin pairs per frame (bins 0..511).
- `HOLD`, 4: cycles the end marker (index 256) is held.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request to stream a frame.
- `ram_addr`, out, 8: result RAM read address (bin pair).
- `ram_ren`, out, 1: RAM read enable.
- `ram_rdata`, in, 4*DW: packed as {real0, imag0, real1, imag1}, valid 1 cycle after the `ram_addr`/`ram_ren` edge.
- `output_index`, out, 9: current bin-pair index; 256 is the frame-end marker.
- `real0`, `imag0`, `real1`, `imag1`, out, DW signed: bins 2k and 2k+1.
- `reset_fft`, out, 1: data gate; 1 tells the consumer to treat the data as zero.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse when the marker first appears.

## Operation

- FSM states and transitions:
  - IDLE → READ on `start`.
  - READ issues addresses 0..NPAIRS-1, then → DRAIN.
  - DRAIN empties the 2-stage pipe, then → MARK.
  - MARK holds index 256 for HOLD cycles, then → IDLE.
- All outputs are registered. Reset value of every output is 0, except `reset_fft` = 1.
- In IDLE: `output_index` = 0, data = 0, `reset_fft` = 1, `busy` = 0.
- Pipeline:
  - Stage 1: address register plus valid/index shadow.
  - Stage 2: the `ram_rdata` capture updates the data outputs and `output_index` together, so index and data always match.
- `reset_fft` is 0 exactly while `output_index` is 0..NPAIRS-1 with valid data; 1 otherwise.
- In MARK: data outputs are forced to 0 and `output_index` = 256.
- `start` while `busy` is ignored, not queued.
- `reset` mid-sweep: next edge returns to IDLE with `output_index` = 0. No marker and no `done` are produced.
- The address counter is 8 bits; the wrap from 255 is the READ exit condition. The counter never rolls back into a second sweep.
- No arithmetic on the data; it is passed through bit-exact with sign preserved.

## Timing

Let E0 be the edge sampling `start` in IDLE.
- After E0: `ram_addr` = 0, `ram_ren` = 1, `busy` = 1.
- After E0+k: `ram_addr` = k, for k = 0..255. `ram_ren` drops after E0+256.
- After E0+2+k: `output_index` = k with the data for pair k and `reset_fft` = 0.
- After E0+258: `output_index` = 256, `reset_fft` = 1, `done` = 1 for this cycle only.
- After E0+258+HOLD: `output_index` = 0, `busy` = 0, state IDLE. A `start` sampled at this edge's following cycle is accepted.
- Total frame time is 258+HOLD+1 cycles, start to IDLE.
- The 0→1 transition of `output_index[8]` occurs exactly once per completed frame.

## Structure

- Shared package `fft_stream_pkg`, containing:
  - `DW`, `NPAIRS`, `IDX_W` (= 9), and `MARK_IDX` (= 256).
  - State enum `stream_state_t` (IDLE, READ, DRAIN, MARK).
  - Packed struct `bin_pair_t` {real0, imag0, real1, imag1}, shared with the FFT result writer and the peak detector.
- One sub-module, `bin_pipe`: the 2-stage valid/index/data delay aligning RAM latency. Its depth is a parameter, for a future registered-output RAM.

## Test plan

- Reset: assert `reset` 2 cycles → all outputs 0, `reset_fft` = 1, `busy` = 0.
- Full sweep: preload RAM pair k = {2k, -2k, 2k+1, -(2k+1)}, pulse `start` → `output_index` k after E0+2+k with matching data for k = 0..255. Marker 256 after E0+258 held 4 cycles, `done` high exactly 1 cycle, then index 0.
- Ignored start: pulse `start` at E0+50 and E0+258 → sweep unaffected, no second frame.
- Reset mid-sweep: `reset` while `output_index` = 100 → index 0 next cycle, `reset_fft` = 1, `output_index[8]` never set, `done` never pulses.
- Back-to-back: `start` in the first IDLE cycle after a frame → second frame begins, same timing as the first.
- Sign integrity: RAM pair 0 = {16'h8000, 16'h7FFF, 16'hFFFF, 0} → outputs equal bit-exactly at index 0.
